// File: rtl/pipe_div_ctrl.sv
// Pipeline stall/bubble sequencing and 32-iteration restoring divider for DIV/DIVU.
module pipe_div_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_stallreq,
  input  logic        exe_div_req,
  input  logic        exe_div_signed,
  input  logic [31:0] exe_src1,
  input  logic [31:0] exe_src2,
  output logic [4:0]  stall,
  output logic        div_busy,
  output logic        div_ready,
  output logic [63:0] div_result
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rem_q, quo_q, dvs_q;
  logic             sign_q_q, sign_r_q;
  logic [2*W-1:0]   result_q;

  logic             src1_neg, src2_neg;
  logic [W-1:0]     src1_abs, src2_abs;
  logic [W:0]       rem_sh;
  logic [W+1:0]     trial;
  logic             take;
  logic [W-1:0]     rem_nx, quo_nx, rem_fix, quo_fix;

  // Operand magnitudes for the signed case
  always_comb begin
    src1_neg = exe_div_signed & exe_src1[W-1];
    src2_neg = exe_div_signed & exe_src2[W-1];
    src1_abs = src1_neg ? (~exe_src1 + W'(1)) : exe_src1;
    src2_abs = src2_neg ? (~exe_src2 + W'(1)) : exe_src2;
  end

  // One restoring shift-subtract step plus final sign fix-up of its result
  always_comb begin
    rem_sh  = {rem_q, quo_q[W-1]};
    trial   = {1'b0, rem_sh} - {2'b00, dvs_q};
    take    = ~trial[W+1];
    rem_nx  = take ? trial[W-1:0] : rem_sh[W-1:0];
    quo_nx  = {quo_q[W-2:0], take};
    rem_fix = sign_r_q ? (~rem_nx + W'(1)) : rem_nx;
    quo_fix = sign_q_q ? (~quo_nx + W'(1)) : quo_nx;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush or a dropped request abandons the division
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (!flush && exe_div_req) begin
          if (exe_src2 == '0) next_state = S_DONE;
          else                next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush || !exe_div_req)                  next_state = S_IDLE;
        else if (cnt == CNT_W'(DIV_CYCLES - 1))     next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Divider datapath and result holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (state == S_IDLE && next_state == S_BUSY) begin
        cnt      <= '0;
        rem_q    <= '0;
        quo_q    <= src1_abs;
        dvs_q    <= src2_abs;
        sign_q_q <= src1_neg ^ src2_neg;
        sign_r_q <= src1_neg;
      end else if (state == S_BUSY) begin
        cnt   <= cnt + CNT_W'(1);
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if (state == S_IDLE && next_state == S_DONE)
        result_q <= {exe_src1, {W{1'b1}}};
      else if (state == S_BUSY && next_state == S_DONE)
        result_q <= {rem_fix, quo_fix};
    end
  end

  // Stall vector: flush > pending division > load-use hazard
  always_comb begin
    stall = 5'b00000;
    if (!rst_n || flush)                      stall = 5'b00000;
    else if (exe_div_req && state != S_DONE)  stall = 5'b01111;
    else if (id_stallreq)                     stall = 5'b00111;
  end

  assign div_busy   = (state != S_IDLE);
  assign div_ready  = (state == S_DONE) && !flush;
  assign div_result = result_q;

endmodule

// File: tb/tb_pipe_div_ctrl.sv
// Scoreboard bench for pipe_div_ctrl: random DIV/DIVU ops against an arithmetic reference.
module tb_pipe_div_ctrl;

  logic        clk, rst_n, flush, id_stallreq, exe_div_req, exe_div_signed;
  logic [31:0] exe_src1, exe_src2;
  logic [4:0]  stall;
  logic        div_busy, div_ready;
  logic [63:0] div_result;

  pipe_div_ctrl #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_stallreq(id_stallreq),
    .exe_div_req(exe_div_req), .exe_div_signed(exe_div_signed),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .stall(stall),
    .div_busy(div_busy), .div_ready(div_ready), .div_result(div_result)
  );

  typedef struct {
    logic [63:0] res;
    int          done;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder takes the dividend's sign
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [31:0] sa, sb_;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa  = $signed(a);
    sb_ = $signed(b);
    return {32'(sa % sb_), 32'(sa / sb_)};
  endfunction

  // Monitor: every div_ready must match the oldest outstanding operation
  always begin
    @(negedge clk);
    #2;
    if (div_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(div_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("div_result", div_result, e.res);
        chk("ready_cycle", 64'(cyc), 64'(e.done));
      end
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic hz);
    exp_t e;
    logic [4:0] xs;
    @(negedge clk);
    exe_src1 = a; exe_src2 = b; exe_div_signed = sgn; exe_div_req = 1'b1;
    id_stallreq = hz & 1'($urandom);
    e.res  = ref_div(a, b, sgn);
    e.done = cyc + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    last_res = e.res;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (cyc == e.done) xs = id_stallreq ? 5'b00111 : 5'b00000;
      else               xs = 5'b01111;
      chk("stall", 64'(stall), 64'(xs));
      if (cyc == e.done) begin
        chk("div_ready", 64'(div_ready), 64'd1);
        break;
      end
      @(negedge clk);
      id_stallreq = hz & 1'($urandom);
    end
    exe_div_req = 1'b0;
    id_stallreq = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; id_stallreq = 1'b0; exe_div_req = 1'b0;
    exe_div_signed = 1'b0; exe_src1 = '0; exe_src2 = '0;
    #1;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_busy", 64'(div_busy), 64'd0);
    chk("reset_ready", 64'(div_ready), 64'd0);
    chk("reset_result", div_result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    do_div(-32'sd7, 32'd2, 1'b1, 1'b0);
    do_div(32'd7, -32'sd2, 1'b1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_div(32'd5, 32'd0, 1'b0, 1'b0);
    do_div(-32'sd5, 32'd0, 1'b1, 1'b0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    do_div(32'd3, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Hazard priority while idle
    @(negedge clk);
    id_stallreq = 1'b1; #1;
    chk("hz_alone", 64'(stall), 64'b00111);
    flush = 1'b1; #1;
    chk("hz_flush", 64'(stall), 64'b00000);
    @(negedge clk);
    flush = 1'b0; id_stallreq = 1'b0;

    // Flush at cycle 10 of a division
    @(negedge clk);
    exe_src1 = 32'd1000; exe_src2 = 32'd3; exe_div_signed = 1'b0; exe_div_req = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_ready", 64'(div_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; exe_div_req = 1'b0; #1;
    chk("flush_idle", 64'(div_busy), 64'd0);
    chk("flush_result", div_result, last_res);
    repeat (3) @(negedge clk);

    // Random mix, with load-use requests during BUSY
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = b >> $urandom_range(0, 31);
        2: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      do_div(a, b, 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    exe_src1 = 32'd12345; exe_src2 = 32'd17; exe_div_signed = 1'b0; exe_div_req = 1'b1;
    repeat (15) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_busy", 64'(div_busy), 64'd0);
    chk("arst_ready", 64'(div_ready), 64'd0);
    chk("arst_result", div_result, 64'd0);
    exe_div_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    do_div(32'd100, 32'd7, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
